// File: rtl/cmd_initiator.sv
// cmd_initiator: host-side bag protocol sequencer (DLINK, DTYPE, DTEMP, then periodic DATA0/DATA1).
// Optional CMD_TEMP_POLL_EN: re-issues DTEMP after every 16th accepted DATA response.
module cmd_initiator #(
  parameter logic [15:0] TOUT   = 16'd50000,
  parameter logic [15:0] PERIOD = 16'd6250,
  parameter logic [1:0]  RETRY  = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  output logic        fs_send,
  output logic [3:0]  send_btype,
  input  logic        fd_send,
  input  logic        fs_read,
  input  logic [3:0]  read_btype,
  output logic        fd_read,
  output logic        linked,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] data_cnt
);

  localparam logic [3:0] DLINK  = 4'b1000;
  localparam logic [3:0] DTYPE  = 4'b1001;
  localparam logic [3:0] DTEMP  = 4'b1010;
  localparam logic [3:0] DATA0  = 4'b1101;
  localparam logic [3:0] DATA1  = 4'b1110;
  localparam logic [3:0] DIDX   = 4'b0101;
  localparam logic [3:0] DPARAM = 4'b0110;
  localparam logic [3:0] DDIDX  = 4'b0111;

  typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_ACK, ST_CHECK, ST_GAP, ST_ERROR} state_t;
  typedef enum logic [1:0] {PH_LINK, PH_TYPE, PH_TEMP, PH_DATA} phase_t;

  state_t      state;
  phase_t      phase;
  logic        toggle;
  logic [1:0]  retry;
  logic [15:0] timer;
  logic [3:0]  rsp_btype;

  function automatic logic [3:0] rsp_code(input phase_t p);
    case (p)
      PH_LINK: rsp_code = DIDX;
      PH_TYPE: rsp_code = DPARAM;
      default: rsp_code = DDIDX;
    endcase
  endfunction

  // Requests are launched on the transition into SEND so fs_send rises together with the state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= PH_LINK;
      toggle     <= 1'b0;
      retry      <= 2'd0;
      timer      <= 16'd0;
      rsp_btype  <= 4'b0000;
      fs_send    <= 1'b0;
      send_btype <= 4'b0000;
      fd_read    <= 1'b0;
      linked     <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      data_cnt   <= 16'd0;
    end else begin
      case (state)
        ST_IDLE, ST_ERROR: begin
          fd_read <= fs_read;
          if (start) begin
            err        <= 1'b0;
            err_code   <= 2'b00;
            data_cnt   <= 16'd0;
            retry      <= 2'd0;
            toggle     <= 1'b0;
            linked     <= 1'b0;
            phase      <= PH_LINK;
            fs_send    <= 1'b1;
            send_btype <= DLINK;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          fd_read <= fs_read;
          if (fd_send) begin
            fs_send <= 1'b0;
            timer   <= 16'd0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (fs_read) begin
            rsp_btype <= read_btype;
            fd_read   <= 1'b1;
            state     <= ST_ACK;
          end else begin
            fd_read <= 1'b0;
            if (timer >= TOUT - 16'd1) begin
              if (retry < RETRY) begin
                retry   <= retry + 2'd1;
                fs_send <= 1'b1;
                state   <= ST_SEND;
              end else begin
                err      <= 1'b1;
                err_code <= 2'b01;
                linked   <= 1'b0;
                state    <= ST_ERROR;
              end
            end else begin
              timer <= timer + 16'd1;
            end
          end
        end
        ST_ACK: begin
          if (!fs_read) begin
            fd_read <= 1'b0;
            state   <= ST_CHECK;
          end else begin
            fd_read <= 1'b1;
          end
        end
        ST_CHECK: begin
          fd_read <= fs_read;
          if (rsp_btype != rsp_code(phase)) begin
            err      <= 1'b1;
            err_code <= 2'b10;
            linked   <= 1'b0;
            fs_send  <= 1'b0;
            state    <= ST_ERROR;
          end else begin
            retry <= 2'd0;
            case (phase)
              PH_LINK: begin
                linked     <= 1'b1;
                phase      <= PH_TYPE;
                send_btype <= DTYPE;
                fs_send    <= 1'b1;
                state      <= ST_SEND;
              end
              PH_TYPE: begin
                phase      <= PH_TEMP;
                send_btype <= DTEMP;
                fs_send    <= 1'b1;
                state      <= ST_SEND;
              end
              PH_TEMP: begin
                phase      <= PH_DATA;
                send_btype <= toggle ? DATA1 : DATA0;
                fs_send    <= 1'b1;
                state      <= ST_SEND;
              end
              default: begin
                data_cnt <= data_cnt + 16'd1;
                toggle   <= ~toggle;
                timer    <= 16'd0;
                state    <= ST_GAP;
              end
            endcase
          end
        end
        ST_GAP: begin
          fd_read <= fs_read;
          if (stop) begin
            linked <= 1'b0;
            state  <= ST_IDLE;
          end else if (timer >= PERIOD - 16'd1) begin
            fs_send <= 1'b1;
            state   <= ST_SEND;
`ifdef CMD_TEMP_POLL_EN
            // data_cnt is never zero here except after a multiple of 16 responses (including wrap).
            if (data_cnt[3:0] == 4'd0) begin
              phase      <= PH_TEMP;
              send_btype <= DTEMP;
            end else begin
              send_btype <= toggle ? DATA1 : DATA0;
            end
`else
            send_btype <= toggle ? DATA1 : DATA0;
`endif
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
